imm_insert_unit: RTL and testbench

- Inverse of the immediate extension step: packs a 32-bit immediate into the encoding fields of a RISC-V instruction word for format I/S/B/J/U.
- Sits in the function-generator instruction assembly path, e.g. a program loader or self-test stimulus generator that builds instruction words for the core.
- Two-stage elastic pipeline with valid/ready handshakes, a range check, and a running count of emitted words.

---
 rtl/imm_insert_unit_pkg.sv | 21 ++
 rtl/imm_insert_unit_if.sv | 17 +
 rtl/imm_insert_unit_field_pack.sv | 30 +++
 rtl/imm_insert_unit.sv | 70 +++++++
 tb/tb_imm_insert_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_insert_unit_pkg.sv
// imm_insert_unit_pkg: immediate format codes and per-format field masks,
// shared with the immediate extension unit.
package imm_insert_unit_pkg;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    function automatic logic [31:0] imm_mask(input logic [2:0] src);
        return src == IMM_I ? MASK_I :
               src == IMM_S ? MASK_S :
               src == IMM_B ? MASK_B :
               src == IMM_J ? MASK_J :
               src == IMM_U ? MASK_U : 32'h0;
    endfunction
endpackage

// File: rtl/imm_insert_unit_if.sv
// imm_insert_unit_if: request/response handshake bundle of the immediate insert unit.
interface imm_insert_unit_if #(parameter int COUNT_W = 16);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          ImmSrc;
    logic [31:0]         imm;
    logic [31:0]         base;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         instruction;
    logic                range_err;
    logic [COUNT_W-1:0]  enc_count;
    modport master (output in_valid, ImmSrc, imm, base, out_ready,
                    input in_ready, out_valid, instruction, range_err, enc_count);
    modport slave (input in_valid, ImmSrc, imm, base, out_ready,
                   output in_ready, out_valid, instruction, range_err, enc_count);
endinterface

// File: rtl/imm_insert_unit_field_pack.sv
// imm_field_pack: packs an immediate into the I/S/B/J/U fields of a base word.
// Range check is built only when IMM_RANGE_CHECK_EN is defined, else o_err=0.
module imm_field_pack
    import imm_insert_unit_pkg::*;
(
    input  logic [2:0]  i_imm_src,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_word,
    output logic        o_err
);
    logic [31:0] w_field;
    always_comb begin
        w_field = i_imm_src == IMM_I ? {i_imm[11:0], 20'h0} :
                  i_imm_src == IMM_S ? {i_imm[11:5], 13'h0, i_imm[4:0], 7'h0} :
                  i_imm_src == IMM_B ? {i_imm[12], i_imm[10:5], 13'h0, i_imm[4:1], i_imm[11], 7'h0} :
                  i_imm_src == IMM_J ? {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h0} :
                  i_imm_src == IMM_U ? {i_imm[31:12], 12'h0} : 32'h0;
        o_word = (i_base & ~imm_mask(i_imm_src)) | w_field;
`ifdef IMM_RANGE_CHECK_EN
        // a value fits n signed bits when every bit from n-1 upward matches
        o_err = (i_imm_src == IMM_I || i_imm_src == IMM_S) ? !(&i_imm[31:11] || ~|i_imm[31:11]) :
                i_imm_src == IMM_B ? i_imm[0] || !(&i_imm[31:12] || ~|i_imm[31:12]) :
                i_imm_src == IMM_J ? i_imm[0] || !(&i_imm[31:20] || ~|i_imm[31:20]) :
                i_imm_src == IMM_U ? |i_imm[11:0] : 1'b1;
`else
        o_err = 1'b0;
`endif
    end
endmodule

// File: rtl/imm_insert_unit.sv
// imm_insert_unit: two-stage elastic pipeline packing immediates into instruction words,
// with a wrapping count of emitted words. Range check gated by IMM_RANGE_CHECK_EN.
module imm_insert_unit
    import imm_insert_unit_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_insert_unit_if.slave bus
);
    logic               r_s1_valid, r_s2_valid, r_s2_err;
    logic [2:0]         r_s1_src;
    logic [31:0]        r_s1_imm, r_s1_base, r_s2_word;
    logic [COUNT_W-1:0] r_count;
    logic               w_s2_ready, w_in_ready, w_err;
    logic [31:0]        w_word;

    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_ready;

    imm_field_pack u_pack (
        .i_imm_src (r_s1_src),
        .i_imm     (r_s1_imm),
        .i_base    (r_s1_base),
        .o_word    (w_word),
        .o_err     (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= '0;
            r_s1_imm   <= '0;
            r_s1_base  <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_src  <= bus.ImmSrc;
                r_s1_imm  <= bus.imm;
                r_s1_base <= bus.base;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_word <= w_word;
                r_s2_err  <= w_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_count <= '0;
        else if (r_s2_valid && bus.out_ready) r_count <= r_count + 1'b1;
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_s2_valid;
    assign bus.instruction = r_s2_word;
    assign bus.range_err   = r_s2_err;
    assign bus.enc_count   = r_count;
endmodule

// File: tb/tb_imm_insert_unit.sv
// tb_imm_insert_unit: directed and randomized checks of imm_insert_unit against a
// round-trip reference model (pack, then re-extract and compare for range errors).
module tb_imm_insert_unit;
    import imm_insert_unit_pkg::*;
    localparam int CW = 4;
    typedef struct {logic [31:0] w; logic e;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_insert_unit_if #(.COUNT_W(CW)) bus ();
    imm_insert_unit #(.COUNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        q[$];
    int          cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        held = 1'b0;
    logic [31:0] held_w;
    logic        held_e;

    function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
        exp_t r;
        logic [31:0] w, back;
        logic ok;
        w = base;
        back = 32'h0;
        ok = 1'b1;
        case (src)
            3'd0: begin w[31:20] = imm[11:0]; back = {{20{w[31]}}, w[31:20]}; end
            3'd1: begin w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; back = {{20{w[31]}}, w[31:25], w[11:7]}; end
            3'd2: begin
                w[31] = imm[12]; w[7] = imm[11]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1];
                back = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            3'd3: begin
                w[31] = imm[20]; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
                back = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            3'd4: begin w[31:12] = imm[31:12]; back = {w[31:12], 12'h0}; end
            default: ok = 1'b0;
        endcase
        r.w = w;
`ifdef IMM_RANGE_CHECK_EN
        r.e = !ok || back != imm;
`else
        r.e = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base, input logic ordy);
        bus.in_valid = v;
        bus.ImmSrc = src;
        bus.imm = imm;
        bus.base = base;
        bus.out_ready = ordy;
    endtask

    // call at a falling edge with inputs already driven; advances one cycle
    task automatic step();
        exp_t e;
        logic out_fire;
        #1;
        chk("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
        if (held) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_word", bus.instruction, held_w);
            chk("hold_err", bus.range_err, held_e);
        end
        if (q.size() == 0) chk("idle_valid", bus.out_valid, 0);
        else if (bus.out_valid && bus.out_ready) begin
            e = q.pop_front();
            chk("word", bus.instruction, e.w);
            chk("err", bus.range_err, e.e);
        end
        held = bus.out_valid && !bus.out_ready;
        held_w = bus.instruction;
        held_e = bus.range_err;
        out_fire = bus.out_valid && bus.out_ready;
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.ImmSrc, bus.imm, bus.base));
        @(posedge clk);
        if (out_fire) cnt = (cnt + 1) % (1 << CW);
        #1;
        chk("enc_count", bus.enc_count, cnt);
        @(negedge clk);
    endtask

    task automatic send_one(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                            input logic [31:0] exp_w, input logic exp_e);
        drive(1'b1, src, imm, base, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("latency_valid", bus.out_valid, 1);
        chk("direct_word", bus.instruction, exp_w);
`ifdef IMM_RANGE_CHECK_EN
        chk("direct_err", bus.range_err, exp_e);
`else
        chk("direct_err", bus.range_err, exp_e & 1'b0);
`endif
        step();
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) step();
        chk("drain_empty", 32'(q.size()), 0);
    endtask

    initial begin
        logic [31:0] t;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_instruction", bus.instruction, 0);
        chk("rst_range_err", bus.range_err, 0);
        chk("rst_enc_count", bus.enc_count, 0);
        @(negedge clk);
        rst = 1'b0;

        send_one(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        chk("first_count", bus.enc_count, 1);
        send_one(IMM_S, 32'h0000_0008, 32'h0000_0023, 32'h0000_0423, 1'b0);
        send_one(IMM_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        send_one(IMM_J, 32'h0000_0008, 32'h0000_006F, 32'h0080_006F, 1'b0);
        send_one(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        send_one(IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        send_one(IMM_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
        send_one(3'd6, 32'h0000_0055, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

        // backpressure: third word must stall until the consumer drains
        drive(1'b1, IMM_I, 32'h1, 32'h13, 1'b0);
        step();
        drive(1'b1, IMM_I, 32'h2, 32'h13, 1'b0);
        step();
        drive(1'b1, IMM_I, 32'h3, 32'h13, 1'b0);
        #1;
        chk("bp_in_ready", bus.in_ready, 0);
        @(negedge clk);
        step();
        step();
        bus.out_ready = 1'b1;
        step();
        drain();

        // asynchronous reset with two words in flight
        drive(1'b1, IMM_U, 32'hABCD_E000, 32'h37, 1'b0);
        step();
        drive(1'b1, IMM_U, 32'h1111_1000, 32'h37, 1'b0);
        step();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_enc_count", bus.enc_count, 0);
        chk("arst_instruction", bus.instruction, 0);
        q.delete();
        cnt = 0;
        held = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        for (int i = 0; i < 17; i++) begin
            drive(1'b1, IMM_J, 32'(i * 2), 32'h6F, 1'b1);
            step();
        end
        drain();
        chk("wrap_count", bus.enc_count, 1);

        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            case ($urandom_range(0, 4))
                0: t = t;
                1: t = {{20{t[11]}}, t[11:0]};
                2: t = {{19{t[12]}}, t[12:1], 1'b0};
                3: t = {{11{t[20]}}, t[20:1], 1'b0};
                default: t = t & 32'hFFFF_F000;
            endcase
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), t, $urandom, $urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
